// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with a binary-to-BCD converter.
// Scan and blink inputs come from a slow divider and are treated as data.
module seg_scan_driver #(
    parameter int LZ_BLANK    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        segclk,
    input  logic        clk_blink,
    input  logic        blink_en,
    input  logic [13:0] score,
    input  logic        score_load,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int  LAST     = SYNC_STAGES - 1;
    localparam logic LZ_ON   = (LZ_BLANK != 0);
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0] segclk_sync_reg;
    logic [SYNC_STAGES-1:0] blink_sync_reg;
    logic                   segclk_prev_reg;
    logic                   scan_tick;
    logic                   blink_active;

    logic [1:0]  idx_reg;
    logic [3:0]  an_reg, an_next;
    logic [6:0]  seg_reg, seg_next;

    state_t      state_reg, state_next;
    logic [13:0] bin_reg, bin_next;
    logic [15:0] acc_reg, acc_next;
    logic [15:0] acc_adj;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] disp_reg, disp_next;
    logic        busy_reg;
    logic [13:0] score_sat;

    logic [3:1]  nib_zero;
    logic [3:1]  above_zero;
    logic [3:0]  lead_blank;
    logic [3:0]  digit_val;

    // Synchronizer chains; first stage takes the raw divider outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            segclk_sync_reg[0] <= 1'b0;
            blink_sync_reg[0]  <= 1'b0;
        end else begin
            segclk_sync_reg[0] <= segclk;
            blink_sync_reg[0]  <= clk_blink;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (clr) begin
                    segclk_sync_reg[gi] <= 1'b0;
                    blink_sync_reg[gi]  <= 1'b0;
                end else begin
                    segclk_sync_reg[gi] <= segclk_sync_reg[gi-1];
                    blink_sync_reg[gi]  <= blink_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign scan_tick    = segclk_sync_reg[LAST] & ~segclk_prev_reg;
    assign blink_active = blink_en & blink_sync_reg[LAST];

    always_ff @(posedge clk) begin
        if (clr) begin
            segclk_prev_reg <= 1'b0;
            idx_reg         <= 2'd3;
        end else begin
            segclk_prev_reg <= segclk_sync_reg[LAST];
            if (scan_tick)
                idx_reg <= idx_reg + 2'd1;
        end
    end

    // Leading-zero detection: a digit is blankable when it and every digit above are zero
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_nib_zero
            assign nib_zero[gi] = (disp_reg[gi*4 +: 4] == 4'd0);
        end
        for (genvar gi = 1; gi < 3; gi++) begin : g_above_zero
            assign above_zero[gi] = nib_zero[gi] & above_zero[gi+1];
        end
    endgenerate
    assign above_zero[3] = nib_zero[3];
    assign lead_blank    = {above_zero & {3{LZ_ON}}, 1'b0};

    assign digit_val = disp_reg[{idx_reg, 2'b00} +: 4];

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Blink overrides leading-zero blanking; neither touches scan state
    always_comb begin
        an_next  = 4'b1111;
        seg_next = SEG_OFF;
        if (!blink_active && !lead_blank[idx_reg]) begin
            an_next  = ~(4'b0001 << idx_reg);
            seg_next = seg_decode(digit_val);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            an_reg  <= 4'b1111;
            seg_reg <= SEG_OFF;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign score_sat = (score > 14'd9999) ? 14'd9999 : score;

    // Double-dabble correction: nibbles of five or more get +3 before the shift
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                        acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        bin_next   = bin_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        disp_next  = disp_reg;
        case (state_reg)
            IDLE: begin
                if (score_load && !busy_reg) begin
                    bin_next   = score_sat;
                    acc_next   = 16'd0;
                    cnt_next   = 4'd0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                acc_next = {acc_adj[14:0], bin_reg[13]};
                bin_next = {bin_reg[12:0], 1'b0};
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'd13)
                    state_next = DONE;
            end
            DONE: begin
                disp_next  = acc_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            bin_reg   <= 14'd0;
            acc_reg   <= 16'd0;
            cnt_reg   <= 4'd0;
            disp_reg  <= 16'd0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            bin_reg   <= bin_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            disp_reg  <= disp_next;
            // Lags the FSM by one edge so busy spans the 15 edges after the load
            busy_reg  <= (state_reg != IDLE);
        end
    end

    assign busy = busy_reg;
    assign an   = an_reg;
    assign seg  = seg_reg;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver: conversions, scanning, blanking and
// blink checked against an arithmetic model of the displayed number.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        clr, segclk, clk_blink, blink_en, score_load;
    logic [13:0] score;
    logic        busy, dp;
    logic [3:0]  an;
    logic [6:0]  seg;

    int total = 0;
    int bad   = 0;

    int model_idx;
    int model_disp;

    logic [6:0] seg_tab [10];

    always #10 clk = ~clk;

    seg_scan_driver #(.LZ_BLANK(1), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .clr        (clr),
        .segclk     (segclk),
        .clk_blink  (clk_blink),
        .blink_en   (blink_en),
        .score      (score),
        .score_load (score_load),
        .busy       (busy),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected pins for the current model digit, from decimal arithmetic
    task automatic expect_pins(output logic [3:0] e_an, output logic [6:0] e_seg);
        int p = 1;
        int d;
        for (int k = 0; k < model_idx; k++) p = p * 10;
        d     = (model_disp / p) % 10;
        e_an  = 4'b1111;
        e_seg = 7'b1111111;
        if (!(blink_en && clk_blink) && !(model_idx > 0 && model_disp / p == 0)) begin
            e_an  = ~(4'b0001 << model_idx);
            e_seg = seg_tab[d];
        end
    endtask

    task automatic check_pins(input string tag);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        expect_pins(e_an, e_seg);
        chk({tag, "_an"}, {12'd0, an}, {12'd0, e_an});
        chk({tag, "_seg"}, {9'd0, seg}, {9'd0, e_seg});
    endtask

    task automatic scan_one(input string tag);
        segclk = 1'b1;
        step(6);
        segclk = 1'b0;
        model_idx = (model_idx + 1) % 4;
        step(6);
        check_pins(tag);
    endtask

    task automatic scan_all(input string tag);
        for (int k = 0; k < 4; k++) scan_one(tag);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step(2);
        clr = 1'b0;
        model_idx  = 3;
        model_disp = 0;
    endtask

    task automatic load(input int v);
        int hi = 0;
        score      = v[13:0];
        score_load = 1'b1;
        step(1);
        score_load = 1'b0;
        chk("busy_at_load", {15'd0, busy}, 16'd0);
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (busy) hi++;
            else if (hi > 0) break;
        end
        chk("busy_len", hi[15:0], 16'd15);
        model_disp = (v > 9999) ? 9999 : v;
        $display("load score=%0d expect display=%0d busy_cycles=%0d", v, model_disp, hi);
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        segclk = 0; clk_blink = 0; blink_en = 0; score_load = 0; score = '0;
        clr = 1'b1;
        step(1);
        chk("rst_an", {12'd0, an}, 16'h000f);
        chk("rst_seg", {9'd0, seg}, 16'h007f);
        chk("rst_dp", {15'd0, dp}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        do_reset();

        // Power-up scan: only the ones digit lit
        scan_all("pwrup");

        load(1234);
        scan_all("s1234");
        load(16383);
        scan_all("sat");
        load(7);
        scan_all("s7");

        // Second request during a conversion is dropped
        score = 14'd42; score_load = 1'b1; step(1); score_load = 1'b0;
        step(3);
        score = 14'd99; score_load = 1'b1; step(1); score_load = 1'b0;
        step(20);
        chk("ign_busy", {15'd0, busy}, 16'd0);
        model_disp = 42;
        $display("load score=42 then 99 while busy, expect display=42");
        scan_all("ignore");
        load(99);
        scan_all("s99");

        // Abort a conversion with clr
        score = 14'd5678; score_load = 1'b1; step(1); score_load = 1'b0;
        step(7);
        clr = 1'b1; step(1); clr = 1'b0;
        model_idx = 3; model_disp = 0;
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_an", {12'd0, an}, 16'h000f);
        step(20);
        chk("abort_busy2", {15'd0, busy}, 16'd0);
        $display("clr mid-conversion of 5678, expect display=0");
        scan_all("abort");

        // clr beats a simultaneous load
        score = 14'd321; score_load = 1'b1; clr = 1'b1; step(1);
        score_load = 1'b0; clr = 1'b0;
        step(2);
        chk("clr_prio_busy", {15'd0, busy}, 16'd0);
        model_idx = 3; model_disp = 0;
        scan_all("clr_prio");

        load(8005);
        scan_all("s8005");

        // Blink: blanked while blinking, scan keeps counting underneath
        blink_en = 1'b1; clk_blink = 1'b1; step(6);
        check_pins("blink_on");
        scan_one("blink_scan");
        scan_one("blink_scan");
        clk_blink = 1'b0; step(6);
        check_pins("blink_off");
        scan_one("blink_after");
        blink_en = 1'b0; clk_blink = 1'b1; step(6);
        check_pins("blink_dis");
        clk_blink = 1'b0;
        $display("blink sequence done");

        for (int r = 0; r < 10; r++) begin
            int v;
            v = (r % 3 == 0) ? int'($urandom_range(9990, 16383)) : int'($urandom_range(0, 9999));
            load(v);
            scan_all("rand");
            if ($urandom_range(0, 1) == 1) scan_one("rand_x");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
